anubis_theta_pipe: RTL and testbench

//  Parametrised, pipelined Anubis theta (diffusion) layer with a valid/ready stream interface.

---
 rtl/anubis_pkg.sv | 25 ++
 rtl/anubis_theta_col.sv | 16 +
 rtl/anubis_theta_pipe.sv | 139 +++++++++++++
 tb/tb_anubis_theta_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anubis_pkg.sv
// Shared Anubis theta definitions: GF(2^8) xtime (poly 0x11d), column type and partial-product helper.
// ANUBIS_THETA_BYPASS_EN (optional) is consumed by anubis_theta_pipe, not by this package.
package anubis_pkg;

    localparam logic [7:0] ANUBIS_POLY = 8'h1d;

    // Byte k of a column sits at [8k+7:8k], so a 32-bit word casts directly.
    typedef logic [3:0][7:0] theta_col_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? ANUBIS_POLY : 8'h00);
    endfunction

    // Partial products shared by the four output bytes:
    // [0]=2(b0^b2) [1]=2(b1^b3) [2]=4(b0^b1) [3]=4(b2^b3)
    function automatic theta_col_t theta_products(input theta_col_t c);
        theta_col_t p;
        p[0] = gf_xtime(c[0] ^ c[2]);
        p[1] = gf_xtime(c[1] ^ c[3]);
        p[2] = gf_xtime(gf_xtime(c[0] ^ c[1]));
        p[3] = gf_xtime(gf_xtime(c[2] ^ c[3]));
        return p;
    endfunction

endpackage

// File: rtl/anubis_theta_col.sv
// Combinational theta for one 32-bit column, given the precomputed 2x/4x partial products.
// Product ordering follows anubis_pkg::theta_products.
module anubis_theta_col
    import anubis_pkg::*;
(
    input  theta_col_t prod,
    input  theta_col_t col_in,
    output theta_col_t col_out
);

    assign col_out[3] = col_in[3] ^ prod[0] ^ prod[2];
    assign col_out[2] = col_in[2] ^ prod[1] ^ prod[2];
    assign col_out[1] = col_in[1] ^ prod[0] ^ prod[3];
    assign col_out[0] = col_in[0] ^ prod[1] ^ prod[3];

endmodule

// File: rtl/anubis_theta_pipe.sv
// Pipelined Anubis theta layer (1 or 2 register stages) with valid/ready stream handshake.
// Optional ANUBIS_THETA_BYPASS_EN adds in_bypass: such beats pass through undiffused.
module anubis_theta_pipe
    import anubis_pkg::*;
#(
    parameter int N_WORDS     = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [32*N_WORDS-1:0]  in_data,
`ifdef ANUBIS_THETA_BYPASS_EN
    input  logic                   in_bypass,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*N_WORDS-1:0]  out_data,
    output logic [1:0]             occupancy
);

    localparam int W = 32 * N_WORDS;

    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $error("anubis_theta_pipe: PIPE_STAGES must be 1 or 2");
    end
    if (N_WORDS < 1 || N_WORDS > 8) begin : g_bad_words
        $error("anubis_theta_pipe: N_WORDS must be 1..8");
    end

    theta_col_t     col_in  [N_WORDS];
    theta_col_t     prod_in [N_WORDS];
    theta_col_t     col_a   [N_WORDS];
    theta_col_t     prod_a  [N_WORDS];
    theta_col_t     col_out [N_WORDS];
    logic           byp_in;
    logic           byp_a;
    logic [W-1:0]   res_data;
    logic           load_out;
    logic           accept;
    logic           drain;

`ifdef ANUBIS_THETA_BYPASS_EN
    assign byp_in = in_bypass;
`else
    assign byp_in = 1'b0;
`endif

    for (genvar k = 0; k < N_WORDS; k++) begin : g_col
        assign col_in[k]  = in_data[32*k +: 32];
        assign prod_in[k] = theta_products(col_in[k]);

        anubis_theta_col u_col (
            .prod    (prod_a[k]),
            .col_in  (col_a[k]),
            .col_out (col_out[k])
        );

        assign res_data[32*k +: 32] = byp_a ? col_a[k] : col_out[k];
    end

    if (PIPE_STAGES == 1) begin : g_one
        logic v0;

        assign in_ready  = ~v0 | out_ready;
        assign out_valid = v0;
        assign load_out  = in_valid & in_ready;
        assign col_a     = col_in;
        assign prod_a    = prod_in;
        assign byp_a     = byp_in;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v0 <= 1'b0;
            end else if (in_ready) begin
                v0 <= in_valid;
            end
        end
    end else begin : g_two
        logic       v0;
        logic       v1;
        logic       rdy1;
        logic       s0_byp;
        theta_col_t s0_col  [N_WORDS];
        theta_col_t s0_prod [N_WORDS];

        assign rdy1      = ~v1 | out_ready;
        assign in_ready  = ~v0 | rdy1;
        assign out_valid = v1;
        assign load_out  = v0 & rdy1;
        assign col_a     = s0_col;
        assign prod_a    = s0_prod;
        assign byp_a     = s0_byp;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v0 <= 1'b0;
                v1 <= 1'b0;
            end else begin
                if (in_ready) v0 <= in_valid;
                if (rdy1)     v1 <= v0;
            end
        end

        // Stage-0 payload needs no reset: it is only observed behind v0.
        always_ff @(posedge clk) begin
            if (in_valid && in_ready) begin
                s0_col  <= col_in;
                s0_prod <= prod_in;
                s0_byp  <= byp_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (load_out) begin
            out_data <= res_data;
        end
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= 2'd0;
        end else begin
            case ({accept, drain})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_anubis_theta_pipe.sv
// Self-checking bench for anubis_theta_pipe: scoreboard of matrix-model results plus directed scenarios.
module tb_anubis_theta_pipe;

    localparam int N_WORDS     = 4;
    localparam int PIPE_STAGES = 1;
    localparam int W           = 32 * N_WORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_bypass;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;

    int            tests = 0;
    int            fails = 0;
    int            out_count = 0;
    logic [W-1:0]  sb[$];
    logic          stall_prev = 1'b0;
    logic [W-1:0]  stall_data;

    anubis_theta_pipe #(.N_WORDS(N_WORDS), .PIPE_STAGES(PIPE_STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef ANUBIS_THETA_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1d : 8'h00);
        end
        return p;
    endfunction

    // H[i][j] depends only on i^j: 0->1, 1->2, 2->4, 3->6
    function automatic logic [7:0] hcoef(input int i, input int j);
        case (i ^ j)
            0:       return 8'h01;
            1:       return 8'h02;
            2:       return 8'h04;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [W-1:0] theta_model(input logic [W-1:0] s);
        logic [W-1:0] r = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(hcoef(i, j), s[32*k + 8*j +: 8]);
                r[32*k + 8*i +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [W-1:0] s;
        for (int k = 0; k < N_WORDS; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                tests++;
                if (out_data !== stall_data) begin
                    fails++;
                    $display("FAIL stall_hold: out_data %h, required %h", out_data, stall_data);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            tests++;
            if (occupancy > 2'(PIPE_STAGES)) begin
                fails++;
                $display("FAIL occupancy_bound: occupancy %0d, limit %0d", occupancy, PIPE_STAGES);
            end
            if (out_valid && out_ready) begin
                tests++;
                out_count++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra: unexpected output %h, scoreboard empty", out_data);
                end else begin
                    logic [W-1:0] exp;
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        fails++;
                        $display("FAIL sb_data: out_data %h, required %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(in_bypass ? in_data : theta_model(in_data));
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic drain_pipe(input string name);
        int cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || occupancy != 0) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk); #1;
        tests++;
        if (sb.size() != 0 || occupancy != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats pending, occupancy %0d, required 0/0", name, sb.size(), occupancy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: valid %b occ %0d data %h ready %b, required 0 0 0 1",
                     out_valid, occupancy, out_data, in_ready);
        end
    endtask

    task automatic test_known();
        logic [31:0] din  [4];
        logic [31:0] dexp [4];
        int          lane [4];
        din[0] = 32'h00000001; dexp[0] = 32'h06040201; lane[0] = 0;
        din[1] = 32'h00000080; dexp[1] = 32'h273a1d80; lane[1] = 0;
        din[2] = 32'h06040201; dexp[2] = 32'h00000001; lane[2] = 0;
        din[3] = 32'h00000001; dexp[3] = 32'h06040201; lane[3] = N_WORDS - 1;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            logic [W-1:0] d = '0;
            logic [W-1:0] e = '0;
            int cyc;
            d[32*lane[t] +: 32] = din[t];
            e[32*lane[t] +: 32] = dexp[t];
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = d;
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 8) begin
                @(posedge clk); #1;
                cyc++;
            end
            tests++;
            if (cyc != PIPE_STAGES) begin
                fails++;
                $display("FAIL known_latency[%0d]: %0d cycles, required %0d", t, cyc, PIPE_STAGES);
            end
            tests++;
            if (out_data !== e) begin
                fails++;
                $display("FAIL known_data[%0d]: out_data %h, required %h", t, out_data, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int start = out_count;
        int not_ready = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b1;
            in_data  = rand_state();
            @(negedge clk);
            if (!in_ready) not_ready++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++;
        if (not_ready != 0) begin
            fails++;
            $display("FAIL b2b_ready: in_ready low %0d cycles, required 0", not_ready);
        end
        repeat (PIPE_STAGES + 1) @(posedge clk);
        #1;
        tests++;
        if (out_count - start != 1000) begin
            fails++;
            $display("FAIL b2b_count: %0d outputs, required 1000", out_count - start);
        end
        drain_pipe("b2b");
    endtask

    task automatic test_random_flow();
        @(posedge clk); #1;
        for (int i = 0; i < 600; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!(in_valid && !in_ready)) in_data = rand_state();
            @(posedge clk); #1;
        end
        drain_pipe("random");
    endtask

    task automatic test_full_drain();
        int cyc = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_state();
        #1;
        while (in_ready && cyc < 10) begin
            @(posedge clk); #1;
            in_data = rand_state();
            #1;
            cyc++;
        end
        tests++;
        if (in_ready !== 1'b0 || occupancy !== 2'(PIPE_STAGES)) begin
            fails++;
            $display("FAIL full_fill: in_ready %b occupancy %0d, required 0 %0d", in_ready, occupancy, PIPE_STAGES);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_ready_comb: in_ready %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (occupancy !== 2'(PIPE_STAGES) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_swap: occupancy %0d valid %b, required %0d 1", occupancy, out_valid, PIPE_STAGES);
        end
        drain_pipe("full");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < PIPE_STAGES + 1; i++) begin
            in_data = rand_state();
            @(posedge clk); #1;
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
            fails++;
            $display("FAIL mid_reset: valid %b occ %0d data %h, required 0 0 0", out_valid, occupancy, out_data);
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_release: in_ready %b valid %b, required 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_discard: out_valid %b after reset, required 0", out_valid);
        end
    endtask

`ifdef ANUBIS_THETA_BYPASS_EN
    task automatic test_bypass();
        int cyc;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = 1'b1; in_data = W'(32'h00000001);
        @(posedge clk); #1;
        in_valid = 1'b0; in_bypass = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (out_data !== W'(32'h00000001) || cyc != PIPE_STAGES) begin
            fails++;
            $display("FAIL bypass_single: out_data %h after %0d cycles, required 1 after %0d", out_data, cyc, PIPE_STAGES);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'b1;
            in_bypass = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 4) != 0);
            in_data   = rand_state();
            @(posedge clk); #1;
            while (!in_ready) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
            end
        end
        in_bypass = 1'b0;
        drain_pipe("bypass");
    endtask
`endif

    initial begin
        test_reset();
        test_known();
        test_back_to_back();
        test_random_flow();
        test_full_drain();
        test_reset_mid();
`ifdef ANUBIS_THETA_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
